// File: rtl/wb_bram.sv
// wb_bram: single-port Wishbone B4 pipelined block RAM.
// Serves as boot ROM (READ_ONLY=1) or scratch RAM (READ_ONLY=0).
// It supports byte-lane writes and a configurable completion latency.
// It reports a bus error for out-of-range addresses and for writes to ROM.
module wb_bram #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 7,
    parameter int    DEPTH      = 128,
    parameter string INIT_FILE  = "",
    parameter bit    READ_ONLY  = 1'b0,
    parameter int    LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      i_wb_cyc,
    input  logic                      i_wb_stb,
    input  logic                      i_wb_we,
    input  logic [ADDR_WIDTH-1:0]     i_wb_addr,
    input  logic [DATA_WIDTH-1:0]     i_wb_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
    output logic                      o_wb_stall,
    output logic                      o_wb_ack,
    output logic                      o_wb_err,
    output logic [DATA_WIDTH-1:0]     o_wb_data
);

    localparam int SEL_W  = DATA_WIDTH / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic              accept;
    logic              addr_ok;
    logic              req_err;
    logic              wr_en;
    logic              rd_en;
    logic [MEM_AW-1:0] mem_idx;

    // Per-stage completion tags; the last stage drives the bus outputs.
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic [LATENCY-1:0]    err_q, err_d;
    logic [LATENCY-1:0]    rdf_q, rdf_d;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY];

    // Decode the request and classify it as a good write, a good read, or an error.
    always_comb begin
        accept  = i_wb_cyc & i_wb_stb & ~i_reset;
        addr_ok = (32'(i_wb_addr) < 32'(DEPTH));
        req_err = ~addr_ok | (i_wb_we & READ_ONLY);
        wr_en   = accept & i_wb_we & ~req_err;
        rd_en   = accept & ~i_wb_we & ~req_err;
        mem_idx = i_wb_addr[MEM_AW-1:0];
    end

    // Memory array write with per-byte lane enables. It is not touched by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int n = 0; n < SEL_W; n++) begin
                if (i_wb_sel[n]) begin
                    mem_q[mem_idx][8*n +: 8] <= i_wb_data[8*n +: 8];
                end
            end
        end
    end

    // Next state of the completion tags. A cycle with CYC low drops every pending completion.
    always_comb begin
        vld_d = '0;
        err_d = '0;
        rdf_d = '0;
        if (i_wb_cyc) begin
            vld_d[0] = accept;
            err_d[0] = req_err;
            rdf_d[0] = ~i_wb_we;
            for (int k = 1; k < LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
                err_d[k] = err_q[k-1];
                rdf_d[k] = rdf_q[k-1];
            end
        end
    end

    // Completion tag registers. Reset clears every in-flight completion.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            vld_q <= '0;
            err_q <= '0;
            rdf_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            rdf_q <= rdf_d;
        end
    end

    // Read data path. The array is read at acceptance, so a write on the previous edge is already visible.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            dat_q[0] <= mem_q[mem_idx];
        end
        for (int k = 1; k < LATENCY; k++) begin
            dat_q[k] <= dat_q[k-1];
        end
    end

    // Bus outputs. Data is forced to zero except while a read ack is presented.
    always_comb begin
        o_wb_stall = 1'b0;
        o_wb_ack   = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
        o_wb_err   = vld_q[LATENCY-1] &  err_q[LATENCY-1];
        o_wb_data  = (o_wb_ack & rdf_q[LATENCY-1]) ? dat_q[LATENCY-1] : '0;
    end

endmodule

// File: tb/tb_wb_bram.sv
// Testbench for wb_bram. Three instances share one bus:
//   0: DEPTH=100, LATENCY=1, RAM
//   1: DEPTH=128, LATENCY=2, RAM
//   2: DEPTH=128, LATENCY=1, ROM (no init image, so only completion type is checked)
// A reference model predicts each completion when a request is sampled.
// A negedge monitor pops those predictions and compares them with the DUT outputs.
module tb_wb_bram;

    localparam int NI = 3;
    localparam int DEP [NI] = '{100, 128, 128};
    localparam int LAT [NI] = '{1, 2, 1};
    localparam bit RO  [NI] = '{1'b0, 1'b0, 1'b1};

    typedef struct {
        int          due;
        bit          err;
        bit          rd;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [6:0]  adr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;

    logic        stall [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic [31:0] rdat  [NI];

    exp_t        sbq    [NI][$];
    logic [31:0] mmem   [NI][128];
    logic [3:0]  mknown [NI][128];

    int edge_n  = 0;
    bit mon_en  = 1'b0;
    int vectors = 0;
    int miscmp  = 0;

    always #5 clk = ~clk;

    wb_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .DEPTH(100), .INIT_FILE(""),
              .READ_ONLY(1'b0), .LATENCY(1)) u_a (
        .clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_err(err[0]), .o_wb_data(rdat[0]));

    wb_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .DEPTH(128), .INIT_FILE(""),
              .READ_ONLY(1'b0), .LATENCY(2)) u_b (
        .clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_err(err[1]), .o_wb_data(rdat[1]));

    wb_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .DEPTH(128), .INIT_FILE(""),
              .READ_ONLY(1'b1), .LATENCY(1)) u_c (
        .clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_err(err[2]), .o_wb_data(rdat[2]));

    initial begin
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 128; a++) begin
                mknown[i][a] = 4'h0;
                mmem[i][a]   = '0;
            end
    end

    // Reference model: applies the bus rules to the inputs sampled at this edge.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rst || !cyc) begin
                while (sbq[i].size() > 0 && sbq[i][$].due >= edge_n)
                    void'(sbq[i].pop_back());
            end else if (stb) begin
                exp_t e;
                e.due  = edge_n + LAT[i] - 1;
                e.err  = (int'(adr) >= DEP[i]) || (we && RO[i]);
                e.rd   = !we;
                e.data = '0;
                e.mask = '0;
                if (!e.err && we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) begin
                            mmem[i][adr][8*b +: 8] = wdat[8*b +: 8];
                            mknown[i][adr][b]      = 1'b1;
                        end
                end
                if (!e.err && !we) begin
                    e.data = mmem[i][adr];
                    for (int b = 0; b < 4; b++)
                        if (mknown[i][adr][b]) e.mask[8*b +: 8] = 8'hFF;
                end
                sbq[i].push_back(e);
            end
        end
    endtask

    // One bus cycle: drive the inputs, let the edge sample them, update the model.
    task automatic cycle(input bit r, input bit c, input bit s, input bit w,
                         input logic [6:0] a, input logic [31:0] d, input logic [3:0] se);
        rst = r; cyc = c; stb = s; we = w; adr = a; wdat = d; sel = se;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 4'h0);
    endtask

    // Monitor: pops the completion due at this edge, or expects a quiet bus.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                vectors++;
                if (stall[i] !== 1'b0) begin
                    miscmp++;
                    $display("FAIL stall[%0d] edge %0d: got %b want 0", i, edge_n, stall[i]);
                end
                while (sbq[i].size() > 0 && sbq[i][0].due < edge_n) begin
                    miscmp++;
                    $display("FAIL lost[%0d] edge %0d: completion due %0d never checked",
                             i, edge_n, sbq[i][0].due);
                    void'(sbq[i].pop_front());
                end
                vectors++;
                if (sbq[i].size() > 0 && sbq[i][0].due == edge_n) begin
                    exp_t e;
                    logic ok;
                    e  = sbq[i].pop_front();
                    ok = (ack[i] === !e.err) && (err[i] === e.err);
                    if (e.rd && !e.err) ok = ok && ((rdat[i] & e.mask) === (e.data & e.mask));
                    else                ok = ok && (rdat[i] === 32'd0);
                    if (!ok) begin
                        miscmp++;
                        $display("FAIL cpl[%0d] edge %0d: got ack=%b err=%b data=%h want ack=%b err=%b data=%h mask=%h",
                                 i, edge_n, ack[i], err[i], rdat[i], !e.err, e.err, e.data, e.mask);
                    end
                end else if (ack[i] !== 1'b0 || err[i] !== 1'b0 || rdat[i] !== 32'd0) begin
                    miscmp++;
                    $display("FAIL quiet[%0d] edge %0d: got ack=%b err=%b data=%h want 0 0 0",
                             i, edge_n, ack[i], err[i], rdat[i]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a request present: it must be ignored.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 7'd9, 32'hFFFF_FFFF, 4'hF);
        mon_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0, 4'h0);
        idle(2);

        // Fill every word, back-to-back, so later reads have known contents.
        for (int a = 0; a < 128; a++)
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'(a), $urandom, 4'hF);
        idle(2);

        // Byte-lane merge, then read it back.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 32'hAABBCCDD, 4'hF);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 32'h11223344, 4'h5);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd3, 32'd0, 4'h0);
        // sel=0 write still completes, and it changes nothing.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd3, 32'h55555555, 4'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd3, 32'd0, 4'hF);
        idle(2);

        // Burst of reads with stb held, then the depth boundary.
        for (int a = 0; a < 4; a++)
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'(a), 32'd0, 4'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd99, 32'd0, 4'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd100, 32'd0, 4'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd120, 32'd0, 4'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd120, 32'h12345678, 4'hF);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd127, 32'd0, 4'h0);
        idle(3);

        // Write immediately followed by a read of the same word.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 7'd2, 32'h12345678, 4'hF);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 32'd0, 4'h0);
        idle(3);

        // Abort: CYC drops the cycle after a read.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 32'd0, 4'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 7'd1, 32'hCAFEF00D, 4'hF);
        idle(3);
        // Reset pulsed the cycle after a read.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd2, 32'd0, 4'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 4'h0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd1, 32'd0, 4'h0);
        idle(3);

        // Randomised traffic with occasional aborts and resets.
        for (int n = 0; n < 600; n++) begin
            bit r, c;
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 11) != 0);
            cycle(r, c, ($urandom_range(0, 3) != 0), 1'($urandom), 7'($urandom),
                  $urandom, 4'($urandom));
        end
        idle(4);

        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (sbq[i].size() != 0) begin
                miscmp++;
                $display("FAIL drain[%0d]: %0d completions outstanding, want 0", i, sbq[i].size());
            end
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
